// File: rtl/matmul_scheduler.sv
// Round-robin scheduler sharing one 3x3 matrix_mult datapath among NUM_REQ requesters; optional RUN timeout via MMSCHED_TIMEOUT_EN.
// Latency: accept -> mm_Enable next cycle; mm_done -> rsp_valid next cycle; next accept 2 cycles after rsp handshake.
// Backpressure: req_ready only in IDLE to the arbitration winner; result held in RESP until the granted rsp_ready.
module matmul_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       Clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*72-1:0]      req_A,
    input  logic [NUM_REQ*72-1:0]      req_B,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [71:0]                rsp_C,
    output logic                       rsp_err,
    output logic                       mm_Enable,
    output logic [71:0]                mm_A,
    output logic [71:0]                mm_B,
    input  logic [71:0]                mm_C,
    input  logic                       mm_done,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);
    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, RUN, RESP, CLEAR} state_t;

    state_t        state;
    logic          win_vld;
    logic [GW-1:0] win_id;
    int            sel;

    // Lowest rotating offset from the last grant wins, so scan offsets high to low.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        sel     = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            sel = (int'(grant_id) + k) % NUM_REQ;
            if (req_valid[GW'(sel)]) begin
                win_vld = 1'b1;
                win_id  = GW'(sel);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && win_vld && !reset) begin
            req_ready[win_id] = 1'b1;
        end
    end

`ifdef MMSCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;
    logic          err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (reset) begin
            state     <= IDLE;
            grant_id  <= GW'(NUM_REQ - 1);
            mm_Enable <= 1'b0;
            mm_A      <= '0;
            mm_B      <= '0;
            rsp_C     <= '0;
            rsp_valid <= '0;
            busy      <= 1'b0;
`ifdef MMSCHED_TIMEOUT_EN
            tmo_cnt   <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        mm_A      <= req_A[win_id*72 +: 72];
                        mm_B      <= req_B[win_id*72 +: 72];
                        grant_id  <= win_id;
                        mm_Enable <= 1'b1;
                        busy      <= 1'b1;
                        state     <= RUN;
`ifdef MMSCHED_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                    end
                end
                RUN: begin
                    if (mm_done) begin
                        rsp_C     <= mm_C;
                        mm_Enable <= 1'b0;
                        rsp_valid <= NUM_REQ'(1) << grant_id;
                        state     <= RESP;
`ifdef MMSCHED_TIMEOUT_EN
                        err_q     <= 1'b0;
                    end else if (tmo_cnt == CW'(TIMEOUT_CYCLES)) begin
                        rsp_C     <= '0;
                        err_q     <= 1'b1;
                        mm_Enable <= 1'b0;
                        rsp_valid <= NUM_REQ'(1) << grant_id;
                        state     <= RESP;
                    end else begin
                        tmo_cnt   <= tmo_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready[grant_id]) begin
                        rsp_valid <= '0;
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    // Wait for the datapath to acknowledge Enable low before re-arbitrating.
                    if (!mm_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_scheduler.sv
// Bench for matmul_scheduler: behavioural matrix_mult model, arbitration model and response scoreboard.
module tb_matmul_scheduler;
    localparam int NUM_REQ = 2;
    localparam int TMO     = 8;
    localparam int DP_LAT  = 4;
`ifdef MMSCHED_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic                       Clock;
    logic                       reset;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*72-1:0]      req_A;
    logic [NUM_REQ*72-1:0]      req_B;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [NUM_REQ-1:0]         rsp_ready;
    logic [71:0]                rsp_C;
    logic                       rsp_err;
    logic                       mm_Enable;
    logic [71:0]                mm_A;
    logic [71:0]                mm_B;
    logic [71:0]                mm_C;
    logic                       mm_done;
    logic                       busy;
    logic [$clog2(NUM_REQ)-1:0] grant_id;

    matmul_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO)) dut (
        .Clock(Clock), .reset(reset),
        .req_valid(req_valid), .req_A(req_A), .req_B(req_B), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_C(rsp_C), .rsp_err(rsp_err),
        .mm_Enable(mm_Enable), .mm_A(mm_A), .mm_B(mm_B), .mm_C(mm_C), .mm_done(mm_done),
        .busy(busy), .grant_id(grant_id)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] ref_mm(input logic [71:0] a, input logic [71:0] b);
        logic [71:0] c;
        int s;
        c = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int k = 0; k < 3; k++) begin
                    s += int'(a[(i*3+k)*8 +: 8]) * int'(b[(k*3+j)*8 +: 8]);
                end
                c[(i*3+j)*8 +: 8] = 8'(s);
            end
        end
        return c;
    endfunction

    function automatic logic [71:0] rnd72();
        return {8'($urandom()), $urandom(), $urandom()};
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int id);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Behavioural datapath: done after DP_LAT enabled cycles, cleared once Enable drops.
    logic        stub_hang;
    logic        stray_done;
    logic        dp_done;
    logic [71:0] dp_c;
    int          dp_cnt;

    always @(posedge Clock) begin
        if (reset || !mm_Enable) begin
            dp_done <= 1'b0;
            dp_cnt  <= 0;
            if (reset) dp_c <= '0;
        end else if (!dp_done && !stub_hang) begin
            if (dp_cnt == DP_LAT - 1) begin
                dp_done <= 1'b1;
                dp_c    <= ref_mm(mm_A, mm_B);
            end
            dp_cnt <= dp_cnt + 1;
        end
    end

    assign mm_done = dp_done | stray_done;
    assign mm_C    = stray_done ? 72'hA5A5_A5A5_A5A5_A5A5_A5 : dp_c;

    typedef struct {
        int          id;
        logic [71:0] c;
        logic        err;
    } exp_t;

    exp_t        q[$];
    int          gq[$];
    int          exp_last;
    logic [71:0] last_c;

    always @(negedge Clock) begin
        exp_t e;
        int   win;
        if (reset) begin
            q.delete();
            exp_last = NUM_REQ - 1;
        end else begin
            if (|(rsp_valid & rsp_ready)) begin
                chk("rsp_pending", 72'(q.size() > 0), 72'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("rsp_valid", rsp_valid, onehot(e.id));
                    chk("rsp_grant", grant_id, e.id);
                    chk("rsp_C", rsp_C, e.c);
                    chk("rsp_err", rsp_err, e.err);
                    last_c = e.c;
                end
            end
            if (|(req_valid & req_ready)) begin
                win = -1;
                for (int k = NUM_REQ; k >= 1; k--) begin
                    if (req_valid[(exp_last + k) % NUM_REQ]) win = (exp_last + k) % NUM_REQ;
                end
                chk("req_ready", req_ready, onehot(win));
                e.id  = win;
                e.err = stub_hang && TMO_EN;
                e.c   = e.err ? 72'd0 : ref_mm(req_A[win*72 +: 72], req_B[win*72 +: 72]);
                q.push_back(e);
                gq.push_back(win);
                exp_last = win;
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic submit(input int r, input logic [71:0] a, input logic [71:0] b);
        bit ok;
        ok = 1'b0;
        tick();
        req_A[r*72 +: 72] = a;
        req_B[r*72 +: 72] = b;
        req_valid[r] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge Clock);
            if (req_ready[r]) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("accept_r%0d", r), 72'(ok), 72'd1);
        tick();
        req_valid[r] = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clock);
            if (!busy && q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 72'(ok), 72'd1);
    endtask

    localparam logic [71:0] T1_A = 72'h09_08_07_06_05_04_03_02_01;
    localparam logic [71:0] T1_B = 72'h01_09_08_07_06_05_04_03_02;
    localparam logic [71:0] T1_C = 72'h5D_96_7E_39_60_51_15_2A_24;

    initial begin
        logic [NUM_REQ-1:0] hit;
        logic [71:0]        a1, b1, a0, b0, bp_c;
        int                 acc, n;
        bit                 ok;

        reset      = 1'b1;
        req_valid  = '1;
        req_A      = '0;
        req_B      = '0;
        rsp_ready  = '1;
        stub_hang  = 1'b0;
        stray_done = 1'b0;
        last_c     = '0;
        exp_last   = NUM_REQ - 1;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_enable", mm_Enable, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, '0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_grant", grant_id, NUM_REQ - 1);
        chk("rst_rsp_C", rsp_C, '0);
        chk("rst_mm_A", mm_A, '0);
        tick();
        req_valid = '0;
        reset     = 1'b0;

        // Single known job on requester 0.
        tick();
        req_A[71:0] = T1_A;
        req_B[71:0] = T1_B;
        req_valid   = 2'b01;
        @(negedge Clock);
        chk("t1_same_cycle_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (rsp_valid != '0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t1_rsp_seen", 72'(ok), 72'd1);
        chk("t1_rsp_C", rsp_C, T1_C);
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        chk("t1_rsp_err", rsp_err, 1'b0);
        drain("t1_drain");

        // Continuous contention after reset: 0,1,0,1.
        do_reset();
        gq.delete();
        for (int r = 0; r < NUM_REQ; r++) begin
            req_A[r*72 +: 72] = rnd72();
            req_B[r*72 +: 72] = rnd72();
        end
        req_valid = '1;
        acc = 0;
        for (int i = 0; i < 400 && acc < 4; i++) begin
            @(negedge Clock);
            hit = req_valid & req_ready;
            tick();
            for (int r = 0; r < NUM_REQ; r++) begin
                if (hit[r]) begin
                    acc++;
                    req_A[r*72 +: 72] = rnd72();
                    req_B[r*72 +: 72] = rnd72();
                end
            end
            if (acc >= 4) req_valid = '0;
        end
        req_valid = '0;
        chk("t2_accepts", acc, 4);
        drain("t2_drain");
        for (int i = 0; i < 4; i++) begin
            if (gq.size() > i) chk($sformatf("t2_grant%0d", i), gq[i], i % 2);
            else chk($sformatf("t2_grant%0d", i), 72'(gq.size()), 72'(i + 1));
        end

        // Response backpressure with a pending request and stray done pulses.
        a1 = rnd72();
        b1 = rnd72();
        a0 = rnd72();
        b0 = rnd72();
        bp_c = ref_mm(a1, b1);
        rsp_ready = '0;
        submit(1, a1, b1);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (rsp_valid != '0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t3_rsp_seen", 72'(ok), 72'd1);
        tick();
        req_A[71:0] = a0;
        req_B[71:0] = b0;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            chk($sformatf("t3_hold_valid%0d", i), rsp_valid, 2'b10);
            chk($sformatf("t3_hold_C%0d", i), rsp_C, bp_c);
            chk($sformatf("t3_hold_en%0d", i), mm_Enable, 1'b0);
            chk($sformatf("t3_hold_ready%0d", i), req_ready, '0);
            tick();
            stray_done = (i >= 2 && i < 5);
        end
        stray_done = 1'b0;
        rsp_ready  = '1;
        @(negedge Clock);
        chk("t3_ready_hs", req_ready, '0);
        @(negedge Clock);
        chk("t3_ready_clear", req_ready, '0);
        @(negedge Clock);
        chk("t3_ready_idle", req_ready, 2'b01);
        tick();
        req_valid = '0;
        drain("t3_drain");

        // Stray done while idle.
        for (int i = 0; i < 3; i++) begin
            tick();
            stray_done = 1'b1;
            @(negedge Clock);
            chk($sformatf("idle_stray_busy%0d", i), busy, 1'b0);
            chk($sformatf("idle_stray_C%0d", i), rsp_C, last_c);
        end
        tick();
        stray_done = 1'b0;
        @(negedge Clock);
        chk("idle_stray_en", mm_Enable, 1'b0);

        // Reset during RUN.
        stub_hang = 1'b1;
        a1 = rnd72();
        b1 = rnd72();
        submit(1, a1, b1);
        @(negedge Clock);
        chk("t4_running", mm_Enable, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        stub_hang = 1'b0;
        @(negedge Clock);
        chk("t4_en", mm_Enable, 1'b0);
        chk("t4_busy", busy, 1'b0);
        chk("t4_rsp_valid", rsp_valid, '0);
        chk("t4_grant", grant_id, NUM_REQ - 1);
        tick();
        req_A[71:0] = rnd72();
        req_B[71:0] = rnd72();
        req_valid   = '1;
        @(negedge Clock);
        chk("t4_first_r0", req_ready, 2'b01);
        tick();
        req_valid = '0;
        submit(1, a1, b1);
        drain("t4_drain");

`ifdef MMSCHED_TIMEOUT_EN
        // Timeout with a datapath that never finishes.
        stub_hang = 1'b1;
        tick();
        req_A[71:0] = rnd72();
        req_B[71:0] = rnd72();
        req_valid[0] = 1'b1;
        @(negedge Clock);
        chk("t5_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        n = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge Clock);
            if (n >= 0) n++;
            if (mm_Enable && n < 0) n = 0;
            if (rsp_valid != '0) break;
        end
        chk("t5_latency", 72'(n), 72'd9);
        chk("t5_err", rsp_err, 1'b1);
        chk("t5_C", rsp_C, '0);
        stub_hang = 1'b0;
        drain("t5_drain");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
